branch_predict_resolve: RTL

// - Parametrised successor to the single-cycle branch condition logic: resolves B-type conditions from ALU flags
//   and adds a direct-mapped branch history table (BHT) of saturating counters for a pipelined core.
// - Sits between IF (prediction lookup) and EX (resolution); drives flush/redirect back to the PC mux.

---
 rtl/branch_pkg.sv | 16 +
 rtl/branch_cond_eval.sv | 20 ++
 rtl/branch_predict_resolve.sv | 102 ++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: B-type funct3 encodings, saturating counter helpers and default counter reset value
package branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam int CTR_INIT_DEF = 1;
  function automatic int unsigned ctr_inc(input int unsigned v, input int unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction
  function automatic int unsigned ctr_dec(input int unsigned v);
    return (v == 0) ? 0 : v - 1;
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational B-type condition from rs1-rs2 flags, flags reserved funct3 010/011
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_overflow,
  input  logic       i_sign,
  output logic       o_cond,
  output logic       o_illegal
);
  assign o_illegal = (i_funct3[2:1] == 2'b01);
  assign o_cond = (i_funct3 == F3_BEQ)  ?  i_zero :
                  (i_funct3 == F3_BNE)  ? ~i_zero :
                  (i_funct3 == F3_BLT)  ? (i_sign != i_overflow) :
                  (i_funct3 == F3_BGE)  ? (i_sign == i_overflow) :
                  (i_funct3 == F3_BLTU) ? ~i_carry :
                  (i_funct3 == F3_BGEU) ?  i_carry : 1'b0;
endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: BHT lookup + B-type resolution with flush/redirect; BRANCH_PERF_EN adds perf counters
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CTR_W     = 2,
  parameter int CTR_INIT  = CTR_INIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_valid_i,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic [2:0]      res_funct3_i,
  input  logic [XLEN-1:0] res_target_i,
  input  logic            res_pred_taken_i,
  input  logic            zero_i,
  input  logic            carry_i,
  input  logic            overflow_i,
  input  logic            sign_i,
  output logic            taken_o,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o,
`ifdef BRANCH_PERF_EN
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispred_count_o,
`endif
  output logic            illegal_o
);
  localparam int DEPTH = 1 << BHT_IDX_W;
  localparam int unsigned CTR_MAX = (1 << CTR_W) - 1;
  logic [CTR_W-1:0] r_bht [DEPTH];
  logic r_pred_valid, r_pred_taken, r_taken, r_flush, r_illegal;
  logic [XLEN-1:0] r_redirect;
  logic w_cond, w_ill, w_legal, w_flush, w_pv, w_unused;
  logic [BHT_IDX_W-1:0] w_pidx, w_ridx;
  logic [CTR_W-1:0] w_ctr, w_ctr_nx;
  branch_cond_eval u_cond (
    .i_funct3  (res_funct3_i),
    .i_zero    (zero_i),
    .i_carry   (carry_i),
    .i_overflow(overflow_i),
    .i_sign    (sign_i),
    .o_cond    (w_cond),
    .o_illegal (w_ill)
  );
  assign w_pidx   = pred_pc_i[BHT_IDX_W+1:2];
  assign w_ridx   = res_pc_i[BHT_IDX_W+1:2];
  assign w_legal  = res_valid_i & ~w_ill;
  assign w_flush  = w_legal & (w_cond != res_pred_taken_i);
  assign w_pv     = pred_valid_i & ~w_flush;
  assign w_ctr    = r_bht[w_ridx];
  assign w_ctr_nx = w_cond ? CTR_W'(ctr_inc(32'(w_ctr), CTR_MAX)) : CTR_W'(ctr_dec(32'(w_ctr)));
  assign w_unused = ^{pred_pc_i[XLEN-1:BHT_IDX_W+2], pred_pc_i[1:0],
                      res_pc_i[XLEN-1:BHT_IDX_W+2], res_pc_i[1:0]};
  // lookup reads the table before this edge's update lands (read-before-write)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bht[i] <= CTR_W'(CTR_INIT);
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_taken      <= 1'b0;
      r_flush      <= 1'b0;
      r_illegal    <= 1'b0;
      r_redirect   <= '0;
    end else begin
      r_pred_valid <= w_pv;
      r_pred_taken <= w_pv & r_bht[w_pidx][CTR_W-1];
      r_taken      <= w_legal & w_cond;
      r_flush      <= w_flush;
      r_illegal    <= res_valid_i & w_ill;
      if (w_legal) begin
        r_redirect    <= w_cond ? res_target_i : res_pc_i + XLEN'(4);
        r_bht[w_ridx] <= w_ctr_nx;
      end
    end
  end
`ifdef BRANCH_PERF_EN
  logic [31:0] r_br_cnt, r_mis_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      r_br_cnt  <= r_br_cnt + 32'(w_legal);
      r_mis_cnt <= r_mis_cnt + 32'(w_flush);
    end
  end
  assign br_count_o      = r_br_cnt;
  assign mispred_count_o = r_mis_cnt;
`endif
  assign pred_valid_o  = r_pred_valid;
  assign pred_taken_o  = r_pred_taken;
  assign taken_o       = r_taken;
  assign flush_o       = r_flush;
  assign illegal_o     = r_illegal;
  assign redirect_pc_o = r_redirect;
endmodule
